wb_sched: RTL and testbench
===========================

WB_SCHED -- requirements
Module: wb_sched

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of write-back requesters (ALU, LSU, MUL/DIV).
REQ-002 SHALL have parameter XLEN, default 64, data width.
REQ-003 SHALL have port clk, input, 1: clock; all state on posedge clk.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port req_valid, input, NREQ: per-requester write-back valid.
REQ-006 SHALL have port req_rd, input, 5*NREQ: per-requester destination register, requester i at bits [5i+4:5i].
REQ-007 SHALL have port req_wdata, input, XLEN*NREQ: per-requester write data, packed the same way.
REQ-008 SHALL have port req_ready, output, NREQ: one-hot grant; a transfer occurs when valid and ready are both high.
REQ-009 SHALL have port wb_wen, output, 1: regfile write enable.
REQ-010 SHALL have port wb_rd, output, 5: regfile write address.
REQ-011 SHALL have port wb_wdata, output, XLEN: regfile write data.
REQ-012 SHALL have port issue_valid, input, 1: decode issues an instruction that writes issue_rd.
REQ-013 SHALL have port issue_rd, input, 5: destination register of the issuing instruction.
REQ-014 SHALL have port flush, input, 1: clears the scoreboard.
REQ-015 SHALL have ports rs1, rs2, input, 5 each: decode source registers to check.
REQ-016 SHALL have ports rs1_busy, rs2_busy, rd_busy, output, 1 each: pending-write status of rs1, rs2 and issue_rd.

Function
REQ-017 SHALL grant at most one requester per cycle, combinationally from req_valid; req_ready SHALL be 0 for every requester that is not valid.
REQ-018 SHALL register the granted rd and wdata into wb_rd and wb_wdata, with a latency of one cycle from the transfer edge to the wb_* outputs.
REQ-019 SHALL set wb_wen to 1 for exactly one cycle per transfer with rd!=0; wb_wen SHALL be 0 after a transfer with rd==0 (the transfer is still accepted) and in any cycle with no grant.
REQ-020 SHALL hold wb_rd and wb_wdata at their last values when wb_wen is 0.
REQ-021 SHALL keep a 32-bit busy vector, where busy[0] is always 0.
REQ-022 SHALL set busy[issue_rd] on a posedge with issue_valid and issue_rd!=0.
REQ-023 SHALL clear busy[rd] on the transfer edge of a granted request.
REQ-024 SHALL let the set win when a set and a clear hit the same rd on the same edge.
REQ-025 SHALL clear all busy bits on a posedge with flush; an issue on the same edge SHALL NOT set its bit.
REQ-026 SHALL keep arbitrating and writing requests that are in flight during a flush.
REQ-027 SHALL drive rs1_busy, rs2_busy and rd_busy combinationally from busy, with no same-cycle bypass of the pending writeback.
REQ-028 SHALL treat issue_valid with rd_busy=1 as a protocol violation; the bench SHALL assert on it, and the RTL behaviour is a plain set.
REQ-029 SHALL update the arbitration pointer only on a transfer, to the index that was granted.

Reset
REQ-030 SHALL, on a posedge with rst, clear busy to 0, set wb_wen to 0, set wb_rd to 0, set wb_wdata to 0, and set the round-robin pointer to NREQ-1.
REQ-031 SHALL make rst dominate flush, issue and grants on the same edge, with no transfer and no output update.
REQ-032 SHALL drive req_ready to 0 while rst is high.

Configuration
REQ-033 SHALL, with WB_SCHED_RR_EN defined, use round-robin arbitration: search starts at pointer+1 modulo NREQ, and requester 0 goes first after reset.
REQ-034 SHALL, without WB_SCHED_RR_EN, use fixed priority (index 0 highest), with the pointer register removed.

Structure
REQ-035 SHALL place NREQ_DEFAULT, the requester index constants (WB_ALU=0, WB_LSU=1, WB_MDU=2) and a wb_req_t struct {rd[4:0], wdata[XLEN-1:0]} in the shared package cpu_pkg.
REQ-036 SHALL put the grant logic in one sub-module, wb_arb, which is combinational and takes the pointer as an input; the scoreboard and output registers SHALL stay in wb_sched.

Verification
REQ-037 SHALL cover: ALU-only valid, rd=5, wdata=0x1234 -> req_ready=001, next cycle wb_wen=1, wb_rd=5, wb_wdata=0x1234.
REQ-038 SHALL cover: all three valid for 3 cycles under RR -> grants 001, 010, 100 in order; under fixed priority -> 001 each cycle.
REQ-039 SHALL cover: issue rd=7, then rs1=7 -> rs1_busy=1; an LSU writeback of rd=7 accepted -> rs1_busy=0 on the following cycle.
REQ-040 SHALL cover: issue rd=9 on the same edge as a transfer of rd=9 -> busy[9]=1 afterward.
REQ-041 SHALL cover: a transfer with rd=0, wdata=0xFF -> req_ready=1, wb_wen stays 0, busy unchanged.
REQ-042 SHALL cover: busy bits 3 and 4 set, flush and issue rd=6 together -> all busy=0; rst mid-stream -> wb_wen=0 and no grant that cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: write-back requester indices, widths and the write-back payload type.
package cpu_pkg;

  localparam int unsigned NREQ_DEFAULT = 3;
  localparam int unsigned XLEN_DEFAULT = 64;
  localparam int unsigned RD_W         = 5;
  localparam int unsigned NREGS        = 32;

  localparam int unsigned WB_ALU = 0;
  localparam int unsigned WB_LSU = 1;
  localparam int unsigned WB_MDU = 2;

  typedef struct packed {
    logic [RD_W-1:0]         rd;
    logic [XLEN_DEFAULT-1:0] wdata;
  } wb_req_t;

  // Width of an index into n requesters (at least one bit).
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arb.sv
// Combinational write-back arbiter: rotating search starting at i_ptr+1 modulo NREQ.
// A pointer held at NREQ-1 degenerates to fixed priority with index 0 highest.
module wb_arb
  import cpu_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT,
  parameter int unsigned PW   = ptr_w(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant_c,
  output logic [PW-1:0]   o_idx_c,
  output logic            o_any_c
);

  always_comb begin
    int unsigned w_pos;
    logic [PW-1:0] w_idx;
    logic w_found;
    w_pos     = 0;
    w_idx     = '0;
    w_found   = 1'b0;
    o_grant_c = '0;
    o_idx_c   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_pos = (32'(i_ptr) + 32'd1 + k) % NREQ;
      w_idx = PW'(w_pos);
      if (!w_found && i_valid[w_idx]) begin
        o_grant_c[w_idx] = 1'b1;
        o_idx_c          = w_idx;
        w_found          = 1'b1;
      end
    end
    o_any_c = w_found;
  end

endmodule

// File: rtl/wb_sched.sv
// Write-back scheduler: arbitrates requesters onto one regfile write port and tracks pending writes.
// Define WB_SCHED_RR_EN for round-robin arbitration; otherwise fixed priority (index 0 highest).
module wb_sched
  import cpu_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT,
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [RD_W*NREQ-1:0]   req_rd,
  input  logic [XLEN*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic                   wb_wen,
  output logic [RD_W-1:0]        wb_rd,
  output logic [XLEN-1:0]        wb_wdata,
  input  logic                   issue_valid,
  input  logic [RD_W-1:0]        issue_rd,
  input  logic                   flush,
  input  logic [RD_W-1:0]        rs1,
  input  logic [RD_W-1:0]        rs2,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  output logic                   rd_busy
);

  localparam int unsigned PW = ptr_w(NREQ);

  logic [NREQ-1:0]  w_grant;
  logic [PW-1:0]    w_gidx;
  logic             w_any;
  logic [PW-1:0]    w_ptr;
  logic             w_xfer;
  logic [RD_W-1:0]  w_sel_rd;
  logic [XLEN-1:0]  w_sel_wdata;
  logic [NREGS-1:0] w_busy_nxt;

  logic [NREGS-1:0] r_busy;
  logic             r_wen;
  logic [RD_W-1:0]  r_rd;
  logic [XLEN-1:0]  r_wdata;

`ifdef WB_SCHED_RR_EN
  logic [PW-1:0] r_ptr;

  // Pointer remembers the last granted index; search resumes just past it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= PW'(NREQ - 1);
    end else if (w_xfer) begin
      r_ptr <= w_gidx;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = PW'(NREQ - 1);
`endif

  wb_arb #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .i_valid   (req_valid),
    .i_ptr     (w_ptr),
    .o_grant_c (w_grant),
    .o_idx_c   (w_gidx),
    .o_any_c   (w_any)
  );

  assign req_ready = rst ? '0 : w_grant;
  assign w_xfer    = w_any & ~rst;

  // Select the granted requester's payload.
  always_comb begin
    w_sel_rd    = '0;
    w_sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gidx == PW'(i)) begin
        w_sel_rd    = req_rd[RD_W*i +: RD_W];
        w_sel_wdata = req_wdata[XLEN*i +: XLEN];
      end
    end
  end

  // Clear on writeback, then set on issue so a same-rd issue wins; flush overrides both.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_xfer) begin
      w_busy_nxt[w_sel_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
    if (flush) begin
      w_busy_nxt = '0;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= '0;
      r_wen   <= 1'b0;
      r_rd    <= '0;
      r_wdata <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_wen  <= w_xfer && (w_sel_rd != '0);
      if (w_xfer && (w_sel_rd != '0)) begin
        r_rd    <= w_sel_rd;
        r_wdata <= w_sel_wdata;
      end
    end
  end

  assign wb_wen   = r_wen;
  assign wb_rd    = r_rd;
  assign wb_wdata = r_wdata;

  // Status reflects registered state only; a writeback in this cycle is not bypassed.
  assign rs1_busy = r_busy[rs1];
  assign rs2_busy = r_busy[rs2];
  assign rd_busy  = r_busy[issue_rd];

endmodule

// File: tb/tb_wb_sched.sv
// Directed self-checking bench for wb_sched with an expected-writeback queue.
module tb_wb_sched;
  import cpu_pkg::*;

  localparam int unsigned N = 3;
  localparam int unsigned X = 64;

  typedef struct packed {
    logic    wen;
    wb_req_t req;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [5*N-1:0] req_rd = '0;
  logic [X*N-1:0] req_wdata = '0;
  logic [N-1:0]   req_ready;
  logic           wb_wen;
  logic [4:0]     wb_rd;
  logic [X-1:0]   wb_wdata;
  logic           issue_valid = 1'b0;
  logic [4:0]     issue_rd = '0;
  logic           flush = 1'b0;
  logic [4:0]     rs1 = '0;
  logic [4:0]     rs2 = '0;
  logic           rs1_busy, rs2_busy, rd_busy;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic [31:0] m_busy = '0;
  logic [4:0]  m_rd = '0;
  logic [63:0] m_wd = '0;

  wb_sched #(.NREQ(N), .XLEN(X)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rd(req_rd), .req_wdata(req_wdata), .req_ready(req_ready),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int unsigned i, input logic v, input logic [4:0] rd, input logic [63:0] wd);
    req_valid[i[1:0]]   = v;
    req_rd[5*i +: 5]    = rd;
    req_wdata[64*i +: 64] = wd;
  endtask

  task automatic clr_req();
    req_valid = '0;
    req_rd    = '0;
    req_wdata = '0;
  endtask

  // One clock: check grant, predict the writeback and busy update, clock, then compare.
  task automatic cyc(input string tag, input logic [N-1:0] exp_rdy);
    exp_t        e;
    int unsigned gi;
    logic [4:0]  rd;
    logic [63:0] wd;
    gi = 0;
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'(exp_rdy));
    if (issue_valid) chk({tag, "_issue_to_busy_rd"}, 64'(rd_busy), 64'd0);
    if (rst) begin
      m_busy = '0; m_rd = '0; m_wd = '0;
      e = '{wen: 1'b0, req: '{rd: 5'd0, wdata: 64'd0}};
    end else begin
      e = '{wen: 1'b0, req: '{rd: m_rd, wdata: m_wd}};
      if (exp_rdy != '0) begin
        for (int unsigned k = 0; k < N; k++) if (exp_rdy[k]) gi = k;
        rd = req_rd[5*gi +: 5];
        wd = req_wdata[64*gi +: 64];
        if (rd != 5'd0) begin
          m_rd = rd; m_wd = wd;
          e = '{wen: 1'b1, req: '{rd: rd, wdata: wd}};
        end
        m_busy[rd] = 1'b0;
      end
      if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
      if (flush) m_busy = '0;
      m_busy[0] = 1'b0;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, "_wen"},   64'(wb_wen), 64'(e.wen));
    chk({tag, "_rd"},    64'(wb_rd),  64'(e.req.rd));
    chk({tag, "_wdata"}, wb_wdata,    e.req.wdata);
    chk({tag, "_rs1_busy"}, 64'(rs1_busy), 64'(m_busy[rs1]));
    chk({tag, "_rs2_busy"}, 64'(rs2_busy), 64'(m_busy[rs2]));
    chk({tag, "_rd_busy"},  64'(rd_busy),  64'(m_busy[issue_rd]));
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset with requests pending: no grants, outputs cleared.
    set_req(WB_ALU, 1'b1, 5'd1, 64'h11);
    set_req(WB_LSU, 1'b1, 5'd2, 64'h22);
    set_req(WB_MDU, 1'b1, 5'd3, 64'h33);
    cyc("rst0", 3'b000);
    cyc("rst1", 3'b000);
    rst = 1'b0;
    clr_req();

    // Single ALU writeback.
    set_req(WB_ALU, 1'b1, 5'd5, 64'h1234);
    cyc("alu", 3'b001);
    chk("alu_exact_rd", 64'(wb_rd), 64'd5);
    chk("alu_exact_wdata", wb_wdata, 64'h1234);
    clr_req();
    cyc("idle", 3'b000);

    // Fresh reset, then all three requesters contend for three cycles.
    rst = 1'b1;
    cyc("rst2", 3'b000);
    rst = 1'b0;
    set_req(WB_ALU, 1'b1, 5'd10, 64'hA);
    set_req(WB_LSU, 1'b1, 5'd11, 64'hB);
    set_req(WB_MDU, 1'b1, 5'd12, 64'hC);
`ifdef WB_SCHED_RR_EN
    cyc("all0", 3'b001);
    cyc("all1", 3'b010);
    cyc("all2", 3'b100);
`else
    cyc("all0", 3'b001);
    cyc("all1", 3'b001);
    cyc("all2", 3'b001);
`endif
    clr_req();

    // Issue rd=7, observe busy, retire via LSU; status drops only after the edge.
    issue_valid = 1'b1; issue_rd = 5'd7; rs1 = 5'd7;
    cyc("iss7", 3'b000);
    issue_valid = 1'b0;
    chk("rs1_busy_7", 64'(rs1_busy), 64'd1);
    set_req(WB_LSU, 1'b1, 5'd7, 64'h77);
    #1;
    chk("no_bypass_7", 64'(rs1_busy), 64'd1);
    cyc("lsu7", 3'b010);
    chk("rs1_clear_7", 64'(rs1_busy), 64'd0);
    clr_req();

    // Issue and writeback of rd=9 on the same edge: set wins.
    set_req(WB_LSU, 1'b1, 5'd9, 64'h99);
    issue_valid = 1'b1; issue_rd = 5'd9; rs1 = 5'd9;
    cyc("same9", 3'b010);
    issue_valid = 1'b0;
    chk("busy9_after", 64'(rs1_busy), 64'd1);
    clr_req();

    // Writeback to x0: accepted, no write, outputs held, busy untouched.
    set_req(WB_ALU, 1'b1, 5'd0, 64'hFF);
    cyc("x0", 3'b001);
    chk("x0_wen", 64'(wb_wen), 64'd0);
    chk("x0_busy9", 64'(rs1_busy), 64'd1);
    clr_req();

    // Set busy 3 and 4, then flush with a concurrent issue and an in-flight MDU writeback.
    issue_valid = 1'b1; issue_rd = 5'd3; rs1 = 5'd3; rs2 = 5'd4;
    cyc("iss3", 3'b000);
    issue_rd = 5'd4;
    cyc("iss4", 3'b000);
    chk("busy3", 64'(rs1_busy), 64'd1);
    chk("busy4", 64'(rs2_busy), 64'd1);
    issue_rd = 5'd6; flush = 1'b1;
    set_req(WB_MDU, 1'b1, 5'd13, 64'hD00D);
    cyc("flush", 3'b100);
    chk("flush_wen", 64'(wb_wen), 64'd1);
    flush = 1'b0; issue_valid = 1'b0;
    chk("flush_busy3", 64'(rs1_busy), 64'd0);
    chk("flush_busy4", 64'(rs2_busy), 64'd0);
    chk("flush_busy6", 64'(rd_busy), 64'd0);
    clr_req();

    // Reset in the middle of traffic, then the same request proceeds.
    set_req(WB_ALU, 1'b1, 5'd14, 64'hE);
    rst = 1'b1;
    cyc("rst_mid", 3'b000);
    chk("rst_mid_wen", 64'(wb_wen), 64'd0);
    rst = 1'b0;
    cyc("post_rst", 3'b001);
    clr_req();
    cyc("tail", 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
